// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE/SHA3 block packer: FSM state encoding,
// default padding bytes and the standard sponge rates.
package shake_pkg;

   typedef enum logic [1:0] {
      ST_ABSORB = 2'd0,
      ST_PAD    = 2'd1,
      ST_STALL  = 2'd2
   } pack_state_t;

   // Domain-separation / first pad byte (SHAKE) and the SHA3 alternative
   localparam logic [7:0] PAD_BEGIN_SHAKE = 8'h1f;
   localparam logic [7:0] PAD_BEGIN_SHA3  = 8'h06;
   // Final pad bit lands in the msb of the last rate byte
   localparam logic [7:0] PAD_END_DEFAULT = 8'h80;

   // Sponge rate widths in bits
   localparam int SHAKE128_RATE = 1344;
   localparam int SHAKE256_RATE = 1088;

endpackage

// File: rtl/shake_pad_lane.sv
// Combinational pad insertion for a single beat. When padding starts in this
// beat, the byte at offset i_nbytes becomes PAD_BEGINNING and all higher bytes
// are zeroed. When the beat is the last of a padded block, PAD_ENDING is OR-ed
// into its top byte (so both pad bytes can share one byte).
module shake_pad_lane
   import shake_pkg::*;
#(
   parameter int         IN_WIDTH      = 8,
   parameter logic [7:0] PAD_BEGINNING = PAD_BEGIN_SHAKE,
   parameter logic [7:0] PAD_ENDING    = PAD_END_DEFAULT
)(
   input  logic [IN_WIDTH-1:0]             i_data,
   input  logic [$clog2(IN_WIDTH/8):0]     i_nbytes,
   input  logic                            i_pad_en,
   input  logic                            i_end_en,
   output logic [IN_WIDTH-1:0]             o_beat
);

   localparam int NB  = IN_WIDTH / 8;
   localparam int NBW = $clog2(NB) + 1;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         localparam logic [NBW-1:0] IDX = NBW'(gi);
         logic [7:0] w_base;

         assign w_base = !i_pad_en          ? i_data[8*gi +: 8] :
                         (IDX == i_nbytes)  ? PAD_BEGINNING     :
                         (IDX >  i_nbytes)  ? 8'h00             :
                                              i_data[8*gi +: 8];

         if (gi == NB - 1) begin : g_top
            assign o_beat[8*gi +: 8] = i_end_en ? (w_base | PAD_ENDING) : w_base;
         end else begin : g_low
            assign o_beat[8*gi +: 8] = w_base;
         end
      end
   endgenerate

endmodule

// File: rtl/shake_block_packer.sv
// Packs byte-oriented message beats into sponge-rate blocks and appends the
// SHAKE/SHA3 multi-rate padding. A completed block is handed to a single
// output register; if that register is still occupied the packer stalls
// holding the finished block in its packing register.
module shake_block_packer
   import shake_pkg::*;
#(
   parameter int         IN_WIDTH      = 8,
   parameter int         RATE_BITS     = SHAKE256_RATE,
   parameter logic [7:0] PAD_BEGINNING = PAD_BEGIN_SHAKE,
   parameter logic [7:0] PAD_ENDING    = PAD_END_DEFAULT
)(
   input  logic                            clk,
   input  logic                            clear_n,
   input  logic [IN_WIDTH-1:0]             in_data,
   input  logic [$clog2(IN_WIDTH/8):0]     in_nbytes,
   input  logic                            in_last,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [RATE_BITS-1:0]            block_out,
   output logic                            block_last,
   output logic                            block_valid,
   input  logic                            block_ready
);

   localparam int NB     = IN_WIDTH / 8;
   localparam int NBW    = $clog2(NB) + 1;
   localparam int NBEATS = RATE_BITS / IN_WIDTH;
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(NBEATS - 1);
   localparam logic [NBW-1:0] NB_FULL  = NBW'(NB);

   pack_state_t            r_state, w_state_next, r_ret_state, w_after_state;
   logic [CW-1:0]          r_cnt;
   logic [RATE_BITS-1:0]   r_pack, w_pack_next, r_block;
   logic                   r_pend, w_after_pend;
   logic                   r_hold_last, r_block_valid, r_block_last, r_alive;
   logic                   w_in_ready, w_beat_en, w_at_end, w_complete;
   logic                   w_out_free, w_padded, w_tail_part;
   logic [IN_WIDTH-1:0]    w_lane_data, w_beat;
   logic [NBW-1:0]         w_lane_nbytes;
   logic                   w_lane_pad, w_lane_end;

   assign w_at_end    = (r_cnt == CNT_LAST);
   assign w_complete  = w_beat_en && w_at_end;
   assign w_out_free  = !r_block_valid || block_ready;
   // Padding begins inside this beat only when it is short; a full last beat
   // pushes PAD_BEGINNING into the following beat.
   assign w_tail_part = in_last && (in_nbytes != NB_FULL);

   shake_pad_lane #(
      .IN_WIDTH      (IN_WIDTH),
      .PAD_BEGINNING (PAD_BEGINNING),
      .PAD_ENDING    (PAD_ENDING)
   ) u_pad_lane (
      .i_data   (w_lane_data),
      .i_nbytes (w_lane_nbytes),
      .i_pad_en (w_lane_pad),
      .i_end_en (w_lane_end),
      .o_beat   (w_beat)
   );

   // Drop the current beat into its slot of the block being assembled
   genvar gi;
   generate
      for (gi = 0; gi < NBEATS; gi++) begin : g_slot
         assign w_pack_next[gi*IN_WIDTH +: IN_WIDTH] =
            (w_beat_en && (r_cnt == CW'(gi))) ? w_beat : r_pack[gi*IN_WIDTH +: IN_WIDTH];
      end
   endgenerate

   // State register; r_alive keeps in_ready low until the first edge after reset
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= ST_ABSORB;
         r_alive <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_alive <= 1'b1;
      end
   end

   // Next-state logic: where the FSM goes after this beat, diverted to STALL
   // when a finished block cannot enter the occupied output register
   always_comb begin
      w_after_state = r_state;
      w_after_pend  = r_pend;
      if (r_state == ST_ABSORB) begin
         if (in_last) begin
            w_after_state = (w_tail_part && w_at_end) ? ST_ABSORB : ST_PAD;
            w_after_pend  = !w_tail_part;
         end
      end else if (r_state == ST_PAD) begin
         w_after_state = w_at_end ? ST_ABSORB : ST_PAD;
         w_after_pend  = 1'b0;
      end

      w_state_next = r_state;
      case (r_state)
         ST_ABSORB, ST_PAD: begin
            if (w_beat_en) begin
               w_state_next = (w_complete && !w_out_free) ? ST_STALL : w_after_state;
            end
         end
         ST_STALL: begin
            if (block_ready) begin
               w_state_next = r_ret_state;
            end
         end
         default: w_state_next = ST_ABSORB;
      endcase
   end

   // Output decode: handshake and the pad-lane controls for each state
   always_comb begin
      w_in_ready    = 1'b0;
      w_beat_en     = 1'b0;
      w_lane_data   = '0;
      w_lane_nbytes = '0;
      w_lane_pad    = 1'b0;
      w_lane_end    = 1'b0;
      w_padded      = 1'b0;
      case (r_state)
         ST_ABSORB: begin
            w_in_ready    = r_alive;
            w_beat_en     = in_valid && r_alive;
            w_lane_data   = in_data;
            w_lane_nbytes = in_nbytes;
            w_lane_pad    = w_tail_part;
            w_lane_end    = w_tail_part && w_at_end;
            w_padded      = w_tail_part;
         end
         ST_PAD: begin
            w_beat_en     = 1'b1;
            w_lane_pad    = r_pend;
            w_lane_end    = w_at_end;
            w_padded      = 1'b1;
         end
         default: ;
      endcase
   end

   // Packing register, beat counter and the context needed to leave STALL
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_pack      <= '0;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_hold_last <= 1'b0;
         r_ret_state <= ST_ABSORB;
      end else if (w_beat_en) begin
         r_pack <= w_pack_next;
         r_cnt  <= w_at_end ? '0 : r_cnt + 1'b1;
         r_pend <= w_after_pend;
         if (w_complete) begin
            r_hold_last <= w_padded;
            r_ret_state <= w_after_state;
         end
      end
   end

   // Output register: take a freshly completed block, or the held one on STALL exit
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_block       <= '0;
         r_block_last  <= 1'b0;
         r_block_valid <= 1'b0;
      end else if (w_complete && w_out_free) begin
         r_block       <= w_pack_next;
         r_block_last  <= w_padded;
         r_block_valid <= 1'b1;
      end else if ((r_state == ST_STALL) && block_ready) begin
         r_block       <= r_pack;
         r_block_last  <= r_hold_last;
         r_block_valid <= 1'b1;
      end else if (block_ready) begin
         r_block_valid <= 1'b0;
      end
   end

   assign in_ready    = w_in_ready;
   assign block_out   = r_block;
   assign block_last  = r_block_last;
   assign block_valid = r_block_valid;

endmodule

// File: tb/tb_shake_block_packer.sv
// Directed bench for shake_block_packer: an 8-bit-beat instance and a
// 32-bit-beat instance, both with a 64-bit rate. Expected blocks are queued
// when stimulus is driven and compared as the DUT hands blocks out.
module tb_shake_block_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clear_n;

   logic [7:0]  in_data8;
   logic [0:0]  in_nbytes8;
   logic        in_last8, in_valid8, in_ready8;
   logic [63:0] block_out8;
   logic        block_last8, block_valid8, block_ready8;

   logic [31:0] in_data32;
   logic [2:0]  in_nbytes32;
   logic        in_last32, in_valid32, in_ready32;
   logic [63:0] block_out32;
   logic        block_last32, block_valid32, block_ready32;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic        last;
      logic [63:0] blk;
   } blk_t;

   blk_t exp8[$], obs8[$], exp32[$], obs32[$];

   shake_block_packer #(.IN_WIDTH(8), .RATE_BITS(64)) dut8 (
      .clk         (clk),
      .clear_n     (clear_n),
      .in_data     (in_data8),
      .in_nbytes   (in_nbytes8),
      .in_last     (in_last8),
      .in_valid    (in_valid8),
      .in_ready    (in_ready8),
      .block_out   (block_out8),
      .block_last  (block_last8),
      .block_valid (block_valid8),
      .block_ready (block_ready8)
   );

   shake_block_packer #(.IN_WIDTH(32), .RATE_BITS(64)) dut32 (
      .clk         (clk),
      .clear_n     (clear_n),
      .in_data     (in_data32),
      .in_nbytes   (in_nbytes32),
      .in_last     (in_last32),
      .in_valid    (in_valid32),
      .in_ready    (in_ready32),
      .block_out   (block_out32),
      .block_last  (block_last32),
      .block_valid (block_valid32),
      .block_ready (block_ready32)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every output transfer; the handshake is stable at the falling edge
   always @(negedge clk) begin
      if (block_valid8 && block_ready8)   obs8.push_back({block_last8, block_out8});
      if (block_valid32 && block_ready32) obs32.push_back({block_last32, block_out32});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send8(input logic [7:0] d, input logic [0:0] nb, input logic last);
      int n = 0;
      in_data8 = d; in_nbytes8 = nb; in_last8 = last; in_valid8 = 1'b1;
      @(negedge clk);
      while (!in_ready8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $error("FAIL send8_timeout: got in_ready=%b expected 1", in_ready8);
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0; in_last8 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] d, input logic [2:0] nb, input logic last);
      int n = 0;
      in_data32 = d; in_nbytes32 = nb; in_last32 = last; in_valid32 = 1'b1;
      @(negedge clk);
      while (!in_ready32 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $error("FAIL send32_timeout: got in_ready=%b expected 1", in_ready32);
      end
      @(posedge clk); #1;
      in_valid32 = 1'b0; in_last32 = 1'b0;
   endtask

   // Wait (bounded) until every queued expectation has been matched
   task automatic drain(input string tag);
      int n = 0;
      while ((exp8.size() != 0 || exp32.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
         while (obs8.size() != 0 && exp8.size() != 0) begin
            blk_t o, e;
            o = obs8.pop_front();
            e = exp8.pop_front();
            check({tag, "_blk8"},  o.blk, e.blk);
            check({tag, "_last8"}, 64'(o.last), 64'(e.last));
            $display("%s: dut8 block %h last %b", tag, o.blk, o.last);
         end
         while (obs32.size() != 0 && exp32.size() != 0) begin
            blk_t o, e;
            o = obs32.pop_front();
            e = exp32.pop_front();
            check({tag, "_blk32"},  o.blk, e.blk);
            check({tag, "_last32"}, 64'(o.last), 64'(e.last));
            $display("%s: dut32 block %h last %b", tag, o.blk, o.last);
         end
      end
      checks++;
      assert (exp8.size() == 0 && exp32.size() == 0) else begin
         errors++;
         $error("FAIL %s_timeout: got %0d/%0d blocks pending expected 0", tag, exp8.size(), exp32.size());
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [63:0] b1, b2;
      int          c0;

      clear_n = 1'b0;
      in_data8 = '0;  in_nbytes8 = '0;  in_last8 = 1'b0;  in_valid8 = 1'b0;  block_ready8 = 1'b1;
      in_data32 = '0; in_nbytes32 = '0; in_last32 = 1'b0; in_valid32 = 1'b0; block_ready32 = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready8",    64'(in_ready8),    64'd0);
      check("rst_in_ready32",   64'(in_ready32),   64'd0);
      check("rst_block_valid8", 64'(block_valid8), 64'd0);
      check("rst_block_out8",   block_out8,        64'd0);
      clear_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready_rise8",  64'(in_ready8),    64'd1);

      // Three bytes, padding in the same block
      exp8.push_back({1'b1, 64'h80000000_1f030201});
      send8(8'h01, 1'b1, 1'b0);
      send8(8'h02, 1'b1, 1'b0);
      send8(8'h03, 1'b1, 1'b1);
      drain("t3bytes");

      // Seven bytes: both pad bytes share the last byte
      exp8.push_back({1'b1, 64'h9f070605_04030201});
      for (int i = 1; i <= 7; i++) send8(8'(i), 1'b1, (i == 7));
      drain("t7bytes");

      // Eight bytes: message fills the block, an extra pad-only block follows
      exp8.push_back({1'b0, 64'h08070605_04030201});
      exp8.push_back({1'b1, 64'h80000000_0000001f});
      for (int i = 1; i <= 8; i++) send8(8'(i), 1'b1, (i == 8));
      drain("t8bytes");

      // Empty tail beat in the last slot: block completes with no PAD beats,
      // so the output is valid one edge after the final beat is accepted
      exp8.push_back({1'b1, 64'h9f070605_04030201});
      for (int i = 1; i <= 7; i++) send8(8'(i), 1'b1, 1'b0);
      send8(8'hee, 1'b0, 1'b1);
      check("tail_latency_valid8", 64'(block_valid8), 64'd1);
      drain("ttail");

      // Sustained streaming: 16 beats in 16 cycles across a block boundary
      for (int j = 0; j < 8; j++) begin
         b1[8*j +: 8] = 8'(8'h21 + j);
         b2[8*j +: 8] = 8'(8'h29 + j);
      end
      exp8.push_back({1'b0, b1});
      exp8.push_back({1'b0, b2});
      c0 = cyc;
      for (int i = 0; i < 16; i++) send8(8'(8'h21 + i), 1'b1, 1'b0);
      check("stream_cycles", 64'(cyc - c0), 64'd16);
      drain("tstream");

      // Back-pressure: second block stalls, both released in order
      block_ready8 = 1'b0;
      exp8.push_back({1'b0, 64'h08070605_04030201});
      exp8.push_back({1'b0, 64'h100f0e0d_0c0b0a09});
      for (int i = 1; i <= 16; i++) send8(8'(i), 1'b1, 1'b0);
      check("stall_in_ready8",    64'(in_ready8),    64'd0);
      check("stall_block_valid8", 64'(block_valid8), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("stall_hold_ready8",  64'(in_ready8),    64'd0);
      block_ready8 = 1'b1;
      drain("tstall");

      // Reset mid-message with a block parked in the output register
      block_ready8 = 1'b0;
      for (int i = 0; i < 12; i++) send8(8'(8'h40 + i), 1'b1, 1'b0);
      @(negedge clk);
      clear_n = 1'b0;
      #2;
      check("clr_block_valid8", 64'(block_valid8), 64'd0);
      check("clr_in_ready8",    64'(in_ready8),    64'd0);
      check("clr_block_out8",   block_out8,        64'd0);
      block_ready8 = 1'b1;
      @(negedge clk);
      clear_n = 1'b1;
      @(posedge clk); #1;
      check("clr_ready_rise8",  64'(in_ready8),    64'd1);
      exp8.push_back({1'b1, 64'h80000000_00001faa});
      send8(8'haa, 1'b1, 1'b1);
      drain("tclear");

      // 32-bit beats: empty last beat as the whole message
      exp32.push_back({1'b1, 64'h80000000_0000001f});
      send32(32'hdeadbeef, 3'd0, 1'b1);
      drain("tempty32");

      // No stray blocks beyond those expected
      repeat (5) @(posedge clk);
      checks++;
      assert (obs8.size() == 0 && obs32.size() == 0) else begin
         errors++;
         $error("FAIL extra_blocks: got %0d/%0d expected 0/0", obs8.size(), obs32.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shake_block_packer.md
SHAKE_BLOCK_PACKER -- requirements
Module: shake_block_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: input beat width in bits; SHALL be a multiple of 8.
REQ-002 Parameter RATE_BITS, default 1088: sponge rate block width in bits; SHALL be a multiple of IN_WIDTH.
REQ-003 Parameter PAD_BEGINNING, default 'h1f: domain/first pad byte (SHAKE; 'h06 for SHA3).
REQ-004 Parameter PAD_ENDING, default 'h80: final pad byte, OR-ed into the last byte of the block.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 clear_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  IN_WIDTH  message beat; byte k at bits [8k+7:8k], byte 0 first in message order.
REQ-008 in_nbytes  input  $clog2(IN_WIDTH/8)+1  valid bytes in beat, low bytes first; IN_WIDTH/8 unless in_last.
REQ-009 in_last  input  1  beat ends the message; in_nbytes 0 legal only with in_last (empty tail).
REQ-010 in_valid / in_ready  input / output  1  input handshake; transfer on both high at clk edge.
REQ-011 block_out  output  RATE_BITS  packed block; message byte j of block at bits [8j+7:8j].
REQ-012 block_last  output  1  block carries padding (final block of message).
REQ-013 block_valid / block_ready  output / input  1  output handshake; transfer on both high at clk edge.

Function
REQ-014 Packing SHALL place consecutive beats at increasing beat index; beat counter width $clog2(RATE_BITS/IN_WIDTH), wraps to 0 after block completes.
REQ-015 FSM states ABSORB, PAD, STALL; reset to ABSORB.
REQ-016 ABSORB: in_ready=1 unless STALL; each accepted non-last beat advances counter; full block completes at counter RATE_BITS/IN_WIDTH-1.
REQ-017 On accepted in_last: byte at index in_nbytes of that beat SHALL be PAD_BEGINNING, higher bytes 0; if in_nbytes=IN_WIDTH/8 the PAD_BEGINNING byte goes to byte 0 of the next beat.
REQ-018 PAD_BEGINNING landing in next beat, or remaining beats to block end: generated in PAD, one zero beat per cycle, in_ready=0.
REQ-019 Last byte of the padded block SHALL be OR-ed with PAD_ENDING; coinciding with PAD_BEGINNING gives PAD_BEGINNING|PAD_ENDING ('h9f by default).
REQ-020 Message ending exactly at a block boundary SHALL yield an extra block: PAD_BEGINNING at byte 0, zeros, PAD_ENDING at last byte, block_last=1.
REQ-021 Completed block SHALL load into output register the cycle it completes if block_valid=0 or block_ready=1 that cycle; else FSM enters STALL holding the packed block, in_ready=0.
REQ-022 STALL exits on output transfer; held block loads the same cycle; FSM returns to ABSORB or PAD.
REQ-023 block_out, block_last SHALL be stable while block_valid=1 and block_ready=0.
REQ-024 Latency: final beat accepted at cycle N -> block_valid=1 at cycle N+1 when no padding beats and no stall.
REQ-025 Sustained throughput: one input beat per cycle when block_ready stays high; no bubble at block boundaries.
REQ-026 After a padded block completes, the next message SHALL start at beat 0 of a fresh block.
REQ-027 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-028 clear_n low SHALL force: FSM ABSORB, counter 0, packing register 0, block_out 0, block_valid 0, block_last 0, in_ready 0 while asserted.
REQ-029 in_ready SHALL rise the first clk edge after clear_n deasserts; partial message content SHALL be discarded.

Structure
REQ-030 Shared package shake_pkg: FSM state enum, PAD_BEGINNING/PAD_ENDING defaults, SHAKE128/SHAKE256 rate constants (1344/1088).
REQ-031 One sub-module shake_pad_lane: combinational pad-byte insertion for one beat given byte offset and last-of-block flag; instantiated once.

Verification (IN_WIDTH=8, RATE_BITS=64 unless noted)
REQ-032 Bytes 01,02,03 (last on 03), block_ready=1 -> one block 'h80000000_1f030201, block_last=1.
REQ-033 Seven bytes 01..07 with last -> block 'h9f070605_04030201, block_last=1.
REQ-034 Eight bytes 01..08 with last -> 'h08070605_04030201 block_last=0, then 'h80000000_0000001f block_last=1.
REQ-035 block_ready=0, 16 bytes streamed -> in_ready low after byte 16; raising block_ready releases both blocks in order, no loss.
REQ-036 clear_n pulsed low after 4 bytes -> block_valid=0, then bytes AA (last) -> block 'h80000000_00001faa.
REQ-037 IN_WIDTH=32, in_nbytes=0 with in_last as first beat -> block 'h80000000_0000001f, block_last=1.
